// File: rtl/lift_pkg.sv
// Shared lift definitions: car FSM states, floor-index width helper and default floor count.
package lift_pkg;

    localparam int unsigned NFloorsDefault = 8;

    typedef enum logic [2:0] {
        StIdle,
        StMoveUp,
        StMoveDown,
        StArrive,
        StDoorWait
    } lift_state_e;

    function automatic int unsigned floor_width(input int unsigned n_floors);
        return (n_floors > 1) ? $clog2(n_floors) : 1;
    endfunction

endpackage

// File: rtl/lift_call_scan.sv
// Combinational summary of latched calls relative to the car position.
module lift_call_scan
    import lift_pkg::*;
#(
    parameter int unsigned N_FLOORS = NFloorsDefault,
    parameter int unsigned FW       = floor_width(N_FLOORS)
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FW-1:0]       current_floor,
    output logic                any_above,
    output logic                any_below,
    output logic                here
);

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        here      = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (pending[i]) begin
                if (FW'(i) > current_floor) any_above = 1'b1;
                if (FW'(i) < current_floor) any_below = 1'b1;
                if (FW'(i) == current_floor) here = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lift_car_controller.sv
// Lift car sequencer: latches calls, moves the car with a SCAN policy and
// hands each arrival to the door controller, waiting for a full open/close.
module lift_car_controller
    import lift_pkg::*;
#(
    parameter int unsigned N_FLOORS            = NFloorsDefault,
    parameter int unsigned FLOOR_TRAVEL_CYCLES = 50,
    parameter int unsigned DOOR_ACK_CYCLES     = 8,
    localparam int unsigned FW                 = floor_width(N_FLOORS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic                door_open,
    output logic                arrive_pulse,
    output logic                hold_door,
    output logic [FW-1:0]       current_floor,
    output logic                moving_up,
    output logic                moving_down,
    output logic [N_FLOORS-1:0] pending,
    output logic                door_fault
);

    localparam int unsigned CW = $clog2(FLOOR_TRAVEL_CYCLES + 1);
    localparam int unsigned AW = $clog2(DOOR_ACK_CYCLES + 1);
    localparam logic [CW-1:0] TravelLast = CW'(FLOOR_TRAVEL_CYCLES - 1);
    localparam logic [AW-1:0] AckLast    = AW'(DOOR_ACK_CYCLES - 1);
    localparam logic [FW-1:0] TopFloor   = FW'(N_FLOORS - 1);

    lift_state_e         state_q, state_d;
    logic [FW-1:0]       floor_q, floor_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [CW-1:0]       trav_cnt_q, trav_cnt_d;
    logic [AW-1:0]       ack_cnt_q, ack_cnt_d;
    logic                last_up_q, last_up_d;
    logic                seen_open_q, seen_open_d;
    logic                fault_q, fault_d;
    logic                hold_q, hold_d;

    logic [N_FLOORS-1:0] floor_mask;
    logic                any_above, any_below, here;

    always_comb begin
        floor_mask = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            floor_mask[i] = (FW'(i) == floor_q);
        end
    end

    lift_call_scan #(
        .N_FLOORS (N_FLOORS),
        .FW       (FW)
    ) u_call_scan (
        .pending       (pending_q),
        .current_floor (floor_q),
        .any_above     (any_above),
        .any_below     (any_below),
        .here          (here)
    );

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        trav_cnt_d  = trav_cnt_q;
        ack_cnt_d   = ack_cnt_q;
        last_up_d   = last_up_q;
        seen_open_d = seen_open_q;
        fault_d     = fault_q;
        hold_d      = 1'b0;

        // Calls for the floor being served are absorbed while the door cycle runs.
        if (state_q == StArrive || state_q == StDoorWait) begin
            pending_d = pending_q | (call_req & ~floor_mask);
        end else begin
            pending_d = pending_q | call_req;
        end

        unique case (state_q)
            StIdle: begin
                if (here) begin
                    state_d = StArrive;
                end else if (any_above && (last_up_q || !any_below)) begin
                    state_d    = StMoveUp;
                    last_up_d  = 1'b1;
                    trav_cnt_d = '0;
                end else if (any_below) begin
                    state_d    = StMoveDown;
                    last_up_d  = 1'b0;
                    trav_cnt_d = '0;
                end
            end
            StMoveUp: begin
                if (trav_cnt_q == TravelLast) begin
                    trav_cnt_d = '0;
                    if (floor_q != TopFloor) begin
                        floor_d = floor_q + 1'b1;
                        if (|(pending_d & (floor_mask << 1))) begin
                            state_d = StArrive;
                        end else if (floor_d == TopFloor) begin
                            state_d = StIdle;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    trav_cnt_d = trav_cnt_q + 1'b1;
                end
            end
            StMoveDown: begin
                if (trav_cnt_q == TravelLast) begin
                    trav_cnt_d = '0;
                    if (floor_q != '0) begin
                        floor_d = floor_q - 1'b1;
                        if (|(pending_d & (floor_mask >> 1))) begin
                            state_d = StArrive;
                        end else if (floor_d == '0) begin
                            state_d = StIdle;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    trav_cnt_d = trav_cnt_q + 1'b1;
                end
            end
            StArrive: begin
                pending_d   = pending_d & ~floor_mask;
                state_d     = StDoorWait;
                seen_open_d = 1'b0;
                ack_cnt_d   = '0;
            end
            StDoorWait: begin
                if (door_open) begin
                    seen_open_d = 1'b1;
                    hold_d      = |(call_req & floor_mask);
                end
                if (seen_open_q && !door_open) begin
                    state_d = StIdle;
                end else if (!seen_open_q && !door_open) begin
                    if (ack_cnt_q == AckLast) begin
                        fault_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            floor_q     <= '0;
            pending_q   <= '0;
            trav_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            last_up_q   <= 1'b1;
            seen_open_q <= 1'b0;
            fault_q     <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            pending_q   <= pending_d;
            trav_cnt_q  <= trav_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            last_up_q   <= last_up_d;
            seen_open_q <= seen_open_d;
            fault_q     <= fault_d;
            hold_q      <= hold_d;
        end
    end

    assign arrive_pulse  = (state_q == StArrive);
    assign moving_up     = (state_q == StMoveUp);
    assign moving_down   = (state_q == StMoveDown);
    assign hold_door     = hold_q;
    assign current_floor = floor_q;
    assign pending       = pending_q;
    assign door_fault    = fault_q;

endmodule

// File: tb/tb_lift_car_controller.sv
// Scoreboard bench for lift_car_controller: expected arrivals are queued at call time
// and matched against each arrive_pulse; a simple door model answers the pulses.
module tb_lift_car_controller;

    localparam int unsigned NF = 8;

    logic          clk;
    logic          reset_n;
    logic [NF-1:0] call_req;
    logic          door_open;
    logic          arrive_pulse;
    logic          hold_door;
    logic [2:0]    current_floor;
    logic          moving_up;
    logic          moving_down;
    logic [NF-1:0] pending;
    logic          door_fault;

    lift_car_controller #(
        .N_FLOORS            (NF),
        .FLOOR_TRAVEL_CYCLES (50),
        .DOOR_ACK_CYCLES     (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .call_req      (call_req),
        .door_open     (door_open),
        .arrive_pulse  (arrive_pulse),
        .hold_door     (hold_door),
        .current_floor (current_floor),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .pending       (pending),
        .door_fault    (door_fault)
    );

    typedef struct {
        int floor;
        int cyc;
    } arr_t;

    arr_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   last_arrive_cyc = 0;
    int   open_dly  = 5;
    int   close_dly = 20;
    bit   door_en   = 1'b1;
    bit   door_busy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Door controller stand-in: opens open_dly and closes close_dly cycles after a pulse.
    initial begin
        door_open = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && arrive_pulse && door_en) begin
                door_busy = 1'b1;
                repeat (open_dly) @(negedge clk);
                door_open = 1'b1;
                repeat (close_dly - open_dly) @(negedge clk);
                door_open = 1'b0;
                door_busy = 1'b0;
            end
        end
    end

    // Arrival monitor: each pulse consumes one scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && arrive_pulse) begin
                last_arrive_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("arrive_spurious", 64'(exp_q.size()), 64'd1);
                end else begin
                    arr_t e;
                    e = exp_q.pop_front();
                    check("arrive_floor", 64'(current_floor), 64'(e.floor));
                    if (e.cyc >= 0) check("arrive_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic push_arrival(input int floor, input int at_cyc);
        arr_t e;
        e.floor = floor;
        e.cyc   = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic call_floor(input int floor);
        call_req = '0;
        call_req[floor] = 1'b1;
        @(negedge clk);
        call_req = '0;
    endtask

    task automatic wait_q_empty(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_door_idle(input int budget);
        int n = 0;
        while ((door_busy || door_open) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("door_idle_timeout", 64'(door_busy), 64'd0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        int k;
        reset_n  = 1'b0;
        call_req = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_floor", 64'(current_floor), 64'd0);
        check("reset_pending", 64'(pending), 64'd0);
        check("reset_outs", 64'({arrive_pulse, hold_door, moving_up, moving_down, door_fault}),
              64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle with no calls for 100 cycles.
        for (int i = 0; i < 10; i++) begin
            repeat (10) @(negedge clk);
            #1;
            check("idle_quiet", 64'({arrive_pulse, hold_door, moving_up, moving_down, door_fault,
                                     current_floor, pending}), 64'd0);
        end

        // Floor 3 from floor 0: pulse lands 151 edges after pending sets.
        close_dly = 200;
        k = cyc;
        push_arrival(3, k + 152);
        call_floor(3);
        #1;
        check("latch_pending3", 64'(pending), 64'h08);
        wait_q_empty("arrive3_timeout", 400);
        @(negedge clk);
        #1;
        check("served_pending3", 64'(pending), 64'd0);
        wait_door_idle(400);
        check("after3_floor", 64'(current_floor), 64'd3);
        check("after3_moving", 64'({moving_up, moving_down, door_fault}), 64'd0);

        // Up 0->5 with calls at 2 (ahead) and 1 (behind) issued mid-travel.
        close_dly = 20;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        k = cyc;
        push_arrival(5, -1);
        call_floor(5);
        while (cyc < k + 60) @(negedge clk);
        check("pass_floor1", 64'(current_floor), 64'd1);
        begin
            arr_t e;
            e.floor = 2;
            e.cyc   = -1;
            exp_q.push_front(e);
        end
        push_arrival(1, -1);
        call_req = 8'h06;
        @(negedge clk);
        call_req = '0;
        wait_q_empty("scan_timeout", 1500);
        wait_door_idle(100);
        check("scan_end_floor", 64'(current_floor), 64'd1);
        check("scan_end_pending", 64'(pending), 64'd0);

        // Re-call floor 4 while its door is open.
        close_dly = 60;
        push_arrival(4, -1);
        call_floor(4);
        wait_q_empty("arrive4_timeout", 400);
        for (int n = 0; n < 40 && !door_open; n++) @(negedge clk);
        check("door4_open", 64'(door_open), 64'd1);
        call_req = 8'h10;
        @(negedge clk);
        call_req = '0;
        #1;
        check("hold_pulse", 64'(hold_door), 64'd1);
        check("hold_pending4", 64'(pending[4]), 64'd0);
        @(negedge clk);
        #1;
        check("hold_single", 64'(hold_door), 64'd0);
        wait_door_idle(100);
        check("hold_no_fault", 64'(door_fault), 64'd0);

        // Door never acknowledges: fault after 8 cycles of waiting.
        door_en = 1'b0;
        push_arrival(6, -1);
        call_floor(6);
        wait_q_empty("arrive6_timeout", 300);
        while (cyc < last_arrive_cyc + 8) @(negedge clk);
        #1;
        check("fault_early", 64'(door_fault), 64'd0);
        @(negedge clk);
        #1;
        check("fault_set", 64'(door_fault), 64'd1);
        door_en = 1'b1;
        push_arrival(2, -1);
        call_floor(2);
        wait_q_empty("after_fault_timeout", 400);
        wait_door_idle(100);
        check("fault_sticky", 64'(door_fault), 64'd1);

        // Asynchronous reset while climbing from floor 2.
        call_floor(7);
        repeat (20) @(negedge clk);
        #1;
        check("climb_up", 64'(moving_up), 64'd1);
        check("climb_floor", 64'(current_floor), 64'd2);
        check("climb_pending", 64'(pending), 64'h80);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_floor", 64'(current_floor), 64'd0);
        check("arst_pending", 64'(pending), 64'd0);
        check("arst_moving", 64'({moving_up, door_fault}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("arst_stays_idle", 64'({moving_up, moving_down, current_floor}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/lift_car_controller.md
# lift_car_controller

Car-motion sequencer that drives the lift between floors and acts as the initiator for the door controller. It latches floor calls, chooses travel direction with a SCAN (elevator) policy, and times inter-floor travel with a cycle counter. On arrival it emits a one-cycle arrival pulse into the door controller's edge input, then holds the car until the door has opened and closed again.

## Interface
- `N_FLOORS`, 8: number of floors, ≥2; `FW = max(1, $clog2(N_FLOORS))`.
- `FLOOR_TRAVEL_CYCLES`, 50: clock cycles to move one floor, ≥1.
- `DOOR_ACK_CYCLES`, 8: cycles allowed for `door_open` to rise after `arrive_pulse`.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `call_req` in N_FLOORS: per-floor call buttons, level or pulse, sampled every cycle.
- `door_open` in 1: door status from the door controller.
- `arrive_pulse` out 1: one-cycle pulse on arrival, to door edge input.
- `hold_door` out 1: one-cycle pulse requesting door re-open (to force_open).
- `current_floor` out FW: floor the car is at or last passed.
- `moving_up`, `moving_down` out 1: high in MOVE_UP / MOVE_DOWN respectively.
- `pending` out N_FLOORS: latched unserved calls.
- `door_fault` out 1: sticky; door failed to acknowledge.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, DOOR_WAIT. Encoding 3-bit, one-hot not required.
- Reset (async): state IDLE, `current_floor`=0, `pending`=0, travel counter 0, `last_dir`=up, all outputs 0, `door_fault`=0.
- Call latch: `pending |= call_req` every cycle, except a call for `current_floor` in ARRIVE or DOOR_WAIT is not latched. In DOOR_WAIT with `door_open`=1, such a call pulses `hold_door` instead.
- IDLE: if `pending[current_floor]` -> ARRIVE. Else if any pending above and (`last_dir`=up or none below) -> MOVE_UP. Else if any pending below -> MOVE_DOWN. Else stay.
- MOVE_x: counter increments each cycle. At count `FLOOR_TRAVEL_CYCLES-1`, clear the counter and step `current_floor` ±1. If `pending` at the new floor is set -> ARRIVE, else remain in MOVE_x. `last_dir` records the direction.
- Floor bounds: MOVE_UP never entered at floor N_FLOORS-1, MOVE_DOWN never at 0. `current_floor` never wraps.
- ARRIVE (1 cycle): `arrive_pulse`=1, clear `pending[current_floor]` -> DOOR_WAIT.
- DOOR_WAIT: an internal `seen_open` flag sets when `door_open`=1.
  - `seen_open` && !`door_open` -> IDLE.
  - If `door_open` has not risen within DOOR_ACK_CYCLES cycles of entry: set `door_fault`, go to IDLE.
- Calls arriving mid-travel for floors ahead in the current direction are served on pass-through. Calls behind are served after reversal.
- All arithmetic unsigned. Counter width `$clog2(FLOOR_TRAVEL_CYCLES+1)`. Ack counter width `$clog2(DOOR_ACK_CYCLES+1)`.

## Timing
- Outputs are registered. `moving_*` and `current_floor` reflect state after the clock edge.
- Decision in IDLE at edge T -> MOVE_x from T+1. `current_floor` changes at edge T+FLOOR_TRAVEL_CYCLES per floor.
- ARRIVE is entered on the same edge as the final floor step. `arrive_pulse` is high for exactly that one cycle.
- Call at the current floor while IDLE: ARRIVE one cycle after `pending` sets (2 cycles after `call_req`).
- `reset_n` deasserted mid-travel: immediate return to reset values. Pending calls are lost.
- `hold_door` pulses at most once per cycle and never outside DOOR_WAIT.

## Structure
- Shared package `lift_pkg`: state enum type, `FW` computation function, and the default `N_FLOORS` constant, also used by the door controller.
- One natural sub-module, `lift_call_scan`: combinational `any_above` / `any_below` / `here` from `pending` and `current_floor`.

## Test plan
- Reset, `call_req`=0 -> IDLE for 100 cycles, all outputs 0, `current_floor`=0.
- Call floor 3 from 0 with `FLOOR_TRAVEL_CYCLES`=50, door model opens 5 / closes 200 cycles after pulse -> `arrive_pulse` at cycle 151 after IDLE decision, `pending`=0, then IDLE after the door closes.
- Car moving up 0->5, call floor 2 at cycle 60 and floor 1 at cycle 60 -> stops at 2, then 5, then reverses and stops at 1.
- Call current floor 4 during DOOR_WAIT with door open -> one `hold_door` pulse, `pending[4]` stays 0.
- Door model never opens -> `door_fault`=1 after 8 cycles in DOOR_WAIT, state returns to IDLE and services the next call.
- Assert `reset_n`=0 mid-MOVE_UP at floor 2 -> `current_floor`=0, `pending`=0, `moving_up`=0 without waiting for a clock edge.
